// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph constants, glyph classes and reader states for the 7-segment bit link
package seg7_pkg;

    // Segment patterns, bit order gfedcba, 1 = segment lit
    localparam logic [6:0] SEG_GLYPH_0 = 7'b0111111;
    localparam logic [6:0] SEG_GLYPH_1 = 7'b0000110;
    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_ALL_ON  = 7'b1111111;

    typedef enum logic [1:0] {
        BIT0,
        BIT1,
        BLANK,
        INVALID
    } glyph_class_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ERR
    } state_t;

endpackage

// File: rtl/seg7_glyph_classify.sv
// rtl/seg7_glyph_classify.sv - combinational map from a segment pattern to its glyph class
module seg7_glyph_classify
    import seg7_pkg::*;
(
    input  logic [6:0]   seg,
    output glyph_class_t glyph_class
);

    // Only the three exact patterns are meaningful; everything else is malformed
    always_comb begin
        glyph_class = INVALID;
        case (seg)
            SEG_GLYPH_0: glyph_class = BIT0;
            SEG_GLYPH_1: glyph_class = BIT1;
            SEG_BLANK:   glyph_class = BLANK;
            SEG_ALL_ON:  glyph_class = INVALID;
            default:     glyph_class = INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_bit_reader.sv
// rtl/seg7_bit_reader.sv - reassembles bit glyphs into words; optional idle timeout under SEG_TIMEOUT_EN
module seg7_bit_reader
    import seg7_pkg::*;
#(
    parameter int NBITS          = 4,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CW            = $clog2(NBITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seg_valid,
    input  logic [6:0]       seg_in,
    output logic [NBITS-1:0] word,
    output logic             word_valid,
    output logic             glyph_err,
    output logic             timeout,
    output logic             busy,
    output logic [CW-1:0]    count
);

    glyph_class_t     glyph_class;
    state_t           state, state_n;
    logic [NBITS-1:0] sr, sr_n, sr_shift, word_n;
    logic [CW-1:0]    count_n;
    logic             word_valid_n, glyph_err_n, timeout_n;
    logic             bit_in, is_bit, timeout_hit;

    seg7_glyph_classify u_classify (
        .seg         (seg_in),
        .glyph_class (glyph_class)
    );

    assign bit_in = (glyph_class == BIT1);
    assign is_bit = (glyph_class == BIT0) || (glyph_class == BIT1);
    assign busy   = (state == COLLECT);

`ifdef SEG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Idle counter runs only while a partial word waits for its next glyph
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (seg_valid || state != COLLECT || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // A glyph in the terminal cycle takes priority over the timeout
    assign timeout_hit = (state == COLLECT) && !seg_valid &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // New shift-register value if the current glyph's bit is accepted
    always_comb begin
        sr_shift = '0;
        if (MSB_FIRST != 0) begin
            sr_shift = (sr << 1) | NBITS'(bit_in);
        end else begin
            sr_shift = (sr >> 1) | (NBITS'(bit_in) << (NBITS - 1));
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_n      = state;
        sr_n         = sr;
        count_n      = count;
        word_n       = word;
        word_valid_n = 1'b0;
        glyph_err_n  = 1'b0;
        timeout_n    = 1'b0;
        case (state)
            IDLE: begin
                if (seg_valid && is_bit) begin
                    if (NBITS == 1) begin
                        word_n       = sr_shift;
                        word_valid_n = 1'b1;
                        sr_n         = '0;
                        count_n      = '0;
                    end else begin
                        sr_n    = sr_shift;
                        count_n = CW'(1);
                        state_n = COLLECT;
                    end
                end else if (seg_valid && glyph_class == INVALID) begin
                    glyph_err_n = 1'b1;
                    state_n     = ERR;
                end
            end
            COLLECT: begin
                if (seg_valid && is_bit) begin
                    if (count == CW'(NBITS - 1)) begin
                        word_n       = sr_shift;
                        word_valid_n = 1'b1;
                        sr_n         = '0;
                        count_n      = '0;
                        state_n      = IDLE;
                    end else begin
                        sr_n    = sr_shift;
                        count_n = count + CW'(1);
                    end
                end else if (seg_valid && glyph_class == INVALID) begin
                    sr_n        = '0;
                    count_n     = '0;
                    glyph_err_n = 1'b1;
                    state_n     = ERR;
                end else if (timeout_hit) begin
                    sr_n      = '0;
                    count_n   = '0;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            ERR: begin
                if (seg_valid && glyph_class == BLANK) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                sr_n    = '0;
                count_n = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            count      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            glyph_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            count      <= count_n;
            word       <= word_n;
            word_valid <= word_valid_n;
            glyph_err  <= glyph_err_n;
            timeout    <= timeout_n;
        end
    end

endmodule

// File: tb/tb_seg7_bit_reader.sv
// tb/tb_seg7_bit_reader.sv - scoreboard bench for seg7_bit_reader, MSB-first and LSB-first instances
module tb_seg7_bit_reader;
    import seg7_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef SEG_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       seg_valid = 1'b0;
    logic [6:0] seg_in = 7'h00;

    logic [N-1:0] word_m, word_l;
    logic         wv_m, wv_l, ge_m, ge_l, to_m, to_l, busy_m, busy_l;
    logic [2:0]   cnt_m, cnt_l;

    seg7_bit_reader #(.NBITS(N), .MSB_FIRST(1), .TIMEOUT_CYCLES(TO)) dut_m (
        .clock(clock), .reset(reset), .seg_valid(seg_valid), .seg_in(seg_in),
        .word(word_m), .word_valid(wv_m), .glyph_err(ge_m), .timeout(to_m),
        .busy(busy_m), .count(cnt_m)
    );

    seg7_bit_reader #(.NBITS(N), .MSB_FIRST(0), .TIMEOUT_CYCLES(TO)) dut_l (
        .clock(clock), .reset(reset), .seg_valid(seg_valid), .seg_in(seg_in),
        .word(word_l), .word_valid(wv_l), .glyph_err(ge_l), .timeout(to_l),
        .busy(busy_l), .count(cnt_l)
    );

    always #5 clock = ~clock;

    // Expected per-cycle view: {word_m, word_l, wv, ge, to, busy, count}
    typedef logic [14:0] obs_t;
    obs_t       status_q[$];
    logic [7:0] word_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: the partial word is just a list of received bits
    bit         bits_q[$];
    logic [3:0] m_wm = 4'h0, m_wl = 4'h0;
    bit         m_err = 1'b0;
    int         m_idle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        m_wm = 4'h0;
        m_wl = 4'h0;
        m_err = 1'b0;
        m_idle = 0;
    endtask

    // Drive one cycle of input and record what the reader must show after the next edge
    task automatic step(input bit v, input logic [6:0] s);
        bit wv = 0, ge = 0, tmo = 0;
        @(negedge clock);
        seg_valid = v;
        seg_in = s;
        if (v) begin
            m_idle = 0;
            if (m_err) begin
                if (s == 7'h00) m_err = 1'b0;
            end else if (s == 7'h3F || s == 7'h06) begin
                bits_q.push_back(s == 7'h06);
                if (bits_q.size() == N) begin
                    m_wm = 4'h0;
                    m_wl = 4'h0;
                    for (int i = 0; i < N; i++) begin
                        if (bits_q[i]) begin
                            m_wm = m_wm + 4'(1 << (N - 1 - i));
                            m_wl = m_wl + 4'(1 << i);
                        end
                    end
                    wv = 1;
                    bits_q.delete();
                    word_q.push_back({m_wm, m_wl});
                end
            end else if (s != 7'h00) begin
                bits_q.delete();
                ge = 1;
                m_err = 1'b1;
            end
        end else if (TMO_EN && bits_q.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                tmo = 1;
                bits_q.delete();
                m_idle = 0;
            end
        end
        status_q.push_back({m_wm, m_wl, wv, ge, tmo, (bits_q.size() > 0), 3'(bits_q.size())});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'($urandom_range(0, 127)));
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i] ? SEG_GLYPH_1 : SEG_GLYPH_0);
    endtask

    task automatic check_words(input string name, input logic [3:0] em, input logic [3:0] el);
        @(posedge clock);
        #2;
        check({name, "_msb"}, 32'(word_m), 32'(em));
        check({name, "_lsb"}, 32'(word_l), 32'(el));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs_m"}, {word_m, wv_m, ge_m, to_m, busy_m, cnt_m}, 32'h0);
        check({name, "_outs_l"}, {word_l, wv_l, ge_l, to_l, busy_l, cnt_l}, 32'h0);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any clock edge
    task automatic pulse_reset(input string name);
        @(posedge clock);
        #2;
        seg_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero(name);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [6:0] rand_glyph();
        int r = $urandom_range(0, 99);
        if (r < 25) return SEG_GLYPH_0;
        if (r < 50) return SEG_GLYPH_1;
        if (r < 70) return SEG_BLANK;
        if (r < 78) return SEG_ALL_ON;
        return 7'($urandom_range(0, 127));
    endfunction

    // Monitor: compares every scoreboarded cycle and every presented word
    initial begin
        obs_t e;
        logic [7:0] w;
        forever begin
            @(posedge clock);
            #1;
            if (status_q.size() > 0) begin
                e = status_q.pop_front();
                check("status_msb", {word_m, wv_m, ge_m, to_m, busy_m, cnt_m},
                      {e[14:11], e[6:0]});
                check("status_lsb", {word_l, wv_l, ge_l, to_l, busy_l, cnt_l},
                      {e[10:7], e[6:0]});
            end
            if (wv_m || wv_l) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word_valid", {wv_m, wv_l}, 32'h0);
                end else begin
                    w = word_q.pop_front();
                    check("word_on_valid", {word_m, word_l}, 32'(w));
                end
            end
        end
    end

    initial begin
        #3;
        check_all_zero("reset_state");
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // 1,0,1,1 back to back
        send_bits(32'b1011, 4);
        check_words("b2b_1011", 4'b1011, 4'b1101);

        // Blank between bits is ignored
        step(1'b1, SEG_GLYPH_1);
        idle(2);
        step(1'b1, SEG_GLYPH_0);
        idle(1);
        step(1'b1, SEG_BLANK);
        idle(2);
        step(1'b1, SEG_GLYPH_0);
        idle(1);
        step(1'b1, SEG_GLYPH_1);
        check_words("blank_1001", 4'b1001, 4'b1001);

        // Invalid glyph, silent ERR, resync on blank
        step(1'b1, SEG_GLYPH_1);
        step(1'b1, SEG_ALL_ON);
        step(1'b1, SEG_GLYPH_0);
        step(1'b1, SEG_GLYPH_1);
        step(1'b1, 7'h55);
        step(1'b1, SEG_BLANK);
        send_bits(32'b0001, 4);
        check_words("resync_0001", 4'b0001, 4'b1000);

        // Long gap inside a word: times out only when the feature is built
        step(1'b1, SEG_GLYPH_1);
        idle(TO);
        send_bits(32'b0011, 4);
        idle(2);

        // Reset mid-word discards the partial word
        send_bits(32'b101, 3);
        pulse_reset("reset_midword");
        idle(3);
        send_bits(32'b0110, 4);
        check_words("after_reset_0110", 4'b0110, 4'b0110);

        // Randomized traffic with occasional long gaps and resets
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) idle($urandom_range(6, 10));
            else if (r < 60) step(1'b1, rand_glyph());
            else if (r == 99) pulse_reset("reset_random");
            else step(1'b0, rand_glyph());
        end
        idle(3);
        @(posedge clock);
        #3;
        check("status_q_drained", 32'(status_q.size()), 32'h0);
        check("word_q_drained", 32'(word_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_bit_reader.md
# seg7_bit_reader

Receive-side counterpart of the single-bit 7-segment display driver. It samples the segment bus whenever the driver's update strobe fires and classifies each glyph as bit 0, bit 1, blank or invalid. It reassembles NBITS consecutive bit glyphs into a parallel word and reports malformed glyphs. It sits at the far end of the segment link and closes the loop for self-check and loopback of the 4-bit encoder path.

## Interface
- NBITS, 4, number of bit glyphs per assembled word (2..16)
- MSB_FIRST, 1, 1: first received bit lands in word[NBITS-1]; 0: first bit lands in word[0]
- TIMEOUT_CYCLES, 255, idle cycles allowed between glyphs of one word (used only with SEG_TIMEOUT_EN)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- seg_valid  in  1  one-cycle strobe: seg_in holds a new glyph this cycle
- seg_in  in  7  segment pattern, bit order gfedcba, 1 = segment lit
- word  out  NBITS  last completed word, held until the next completion
- word_valid  out  1  one-cycle pulse: word updated
- glyph_err  out  1  one-cycle pulse: invalid glyph received
- timeout  out  1  one-cycle pulse: partial word abandoned by timeout
- busy  out  1  partial word in progress (state COLLECT)
- count  out  $clog2(NBITS+1)  bits collected for the current word

## Operation
- Glyph classes: 7'b0111111 = bit 0; 7'b0000110 = bit 1; 7'b0000000 = blank; any other pattern, including 7'b1111111, = invalid.
- seg_in is ignored in any cycle where seg_valid = 0.
- States: IDLE, COLLECT, ERR.
- IDLE, bit glyph: shift the bit into the shift register, count = 1, go to COLLECT. If NBITS = 1, complete immediately.
- IDLE, blank glyph: no effect.
- IDLE, invalid glyph: pulse glyph_err, go to ERR.
- COLLECT, bit glyph: shift the bit in and increment count. On the NBITS-th bit:
  - load word from the shift register including this bit,
  - pulse word_valid,
  - set count = 0 and go to IDLE.
- COLLECT, blank glyph: no effect; the partial word is retained.
- COLLECT, invalid glyph: discard the partial word, count = 0, pulse glyph_err, go to ERR.
- ERR: stay until a blank glyph arrives, then go to IDLE. Bit glyphs and invalid glyphs in ERR are dropped silently with no further glyph_err pulses. This is the resync rule.
- Shift rule:
  - MSB_FIRST = 1: sr <= {sr[NBITS-2:0], bit}.
  - MSB_FIRST = 0: sr <= {bit, sr[NBITS-1:1]}.
- busy = (state == COLLECT).

## Timing
- Reset values: word = 0, word_valid = 0, glyph_err = 0, timeout = 0, busy = 0, count = 0, shift register = 0, state IDLE, timeout counter = 0.
- All outputs are registered.
- word_valid, word and glyph_err appear on the clock edge that samples the triggering seg_valid, so they are visible in the following cycle (latency 1).
- Back-to-back seg_valid on every cycle is supported with no dead cycles. The bit after a completion starts the next word.
- Every pulse output is exactly one cycle wide.
- Reset mid-word discards all partial state. No word_valid is emitted for a partial word.
- word_valid and glyph_err are mutually exclusive in any one cycle.

## Configuration
- SEG_TIMEOUT_EN defined:
  - The idle counter clears on every seg_valid and increments each cycle in COLLECT without seg_valid.
  - When it reaches TIMEOUT_CYCLES: pulse timeout, discard the partial word, count = 0, go to IDLE. Do not go to ERR.
  - If seg_valid coincides with the terminal count, the glyph wins and no timeout fires.
- SEG_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and a partial word waits indefinitely.

## Structure
- Shared package seg7_pkg contains:
  - glyph constants SEG_GLYPH_0, SEG_GLYPH_1, SEG_BLANK, SEG_ALL_ON,
  - the glyph-class enum (BIT0, BIT1, BLANK, INVALID),
  - the state enum (IDLE, COLLECT, ERR).
- The display driver uses the same glyph constants.
- One sub-module: seg7_glyph_classify, a combinational map from seg_in to glyph class. It is reusable by display-side checkers.

## Test plan
- Reset, then glyphs 1,0,1,1 on consecutive cycles with MSB_FIRST = 1 -> word = 4'b1011 and one word_valid pulse one cycle after the fourth glyph.
- Same stream with MSB_FIRST = 0 -> word = 4'b1101.
- Glyphs 1,0, then blank, then 0,1 with gaps between strobes -> the blank is ignored, word = 4'b1001, single word_valid.
- Glyphs 1, 7'b1111111, 0, 1, blank, then 0,0,0,1:
  - one glyph_err pulse,
  - no pulses while in ERR,
  - then word = 4'b0001.
- With SEG_TIMEOUT_EN and TIMEOUT_CYCLES = 8: glyph 1, then 8 idle cycles -> timeout pulse, count = 0, busy = 0. Following glyphs 0,0,1,1 -> word = 4'b0011.
- Reset asserted after 3 bits -> all outputs 0 immediately, and no word_valid afterwards.
